// File: rtl/vdec_hs_crc_chk.sv
// Serial/parallel CRC checker: payload and received parity go through one LFSR;
// a zero syndrome after the parity field means the block passed.
module vdec_hs_crc_chk #(
    parameter int unsigned      CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter int unsigned      DATA_W = 1,
    parameter int unsigned      LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blk_start,
    input  logic [LEN_W-1:0]  blk_len,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              crc_done,
    output logic              crc_ok,
    output logic [CRC_W-1:0]  crc_syn
);

    // Counter must hold both blk_len and CRC_W (up to 24).
    localparam int unsigned      CNT_W    = (LEN_W > 6) ? LEN_W : 6;
    localparam logic [CNT_W-1:0] STEP     = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CRC_LD   = CNT_W'(CRC_W);
    localparam logic [CNT_W-1:0] LEN_MASK = ~CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StPayload, StParity, StDone} state_e;

    state_e             state_q, state_d;
    logic [CRC_W-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ok_q, ok_d;
    logic [CRC_W-1:0]   syn_q, syn_d;
    logic [CRC_W-1:0]   r_upd;
    logic [CNT_W-1:0]   cnt_dec;
    logic [CNT_W-1:0]   len_ld;

    // DATA_W single-bit steps chained combinationally, din MSB first.
    always_comb begin
        r_upd = r_q;
        for (int k = DATA_W - 1; k >= 0; k--) begin
            r_upd = {r_upd[CRC_W-2:0] ^ ({(CRC_W-1){r_upd[CRC_W-1]}} & POLY[CRC_W-1:1]),
                     r_upd[CRC_W-1] ^ din[k]};
        end
    end

    assign cnt_dec = cnt_q - STEP;
    assign len_ld  = CNT_W'(blk_len) & LEN_MASK;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        syn_d   = syn_q;
        if (blk_start) begin
            r_d   = '0;
            ok_d  = 1'b0;
            syn_d = '0;
            if (len_ld == '0) begin
                state_d = StParity;
                cnt_d   = CRC_LD;
            end else begin
                state_d = StPayload;
                cnt_d   = len_ld;
            end
        end else begin
            case (state_q)
                StPayload: begin
                    if (din_vld) begin
                        r_d   = r_upd;
                        cnt_d = cnt_dec;
                        if (cnt_dec == '0) begin
                            state_d = StParity;
                            cnt_d   = CRC_LD;
                        end
                    end
                end
                StParity: begin
                    if (din_vld) begin
                        r_d   = r_upd;
                        cnt_d = cnt_dec;
                        if (cnt_dec == '0) begin
                            // Result registered here so it is already valid in StDone.
                            state_d = StDone;
                            ok_d    = (r_upd == '0);
                            syn_d   = r_upd;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            syn_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            syn_q   <= syn_d;
        end
    end

    assign busy     = (state_q == StPayload) || (state_q == StParity);
    assign crc_done = (state_q == StDone);
    assign crc_ok   = ok_q;
    assign crc_syn  = syn_q;

endmodule

// File: tb/tb_vdec_hs_crc_chk.sv
// Directed bench for vdec_hs_crc_chk: default 16-bit serial, 8-bit parallel and
// 24-bit configurations, checked against hand-computed results and a bitwise model.
module tb_vdec_hs_crc_chk;

    localparam logic [71:0] MSG  = "123456789";
    localparam logic [87:0] GOOD = {MSG, 16'h31C3};
    localparam logic [87:0] BAD  = {MSG, 16'h31C2};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
    int base;

    logic        blk_start_a, din_vld_a, din_a, busy_a, done_a, ok_a;
    logic [15:0] blk_len_a, syn_a;
    logic        blk_start_b, din_vld_b, busy_b, done_b, ok_b;
    logic [15:0] blk_len_b, syn_b;
    logic [7:0]  din_b;
    logic        blk_start_c, din_vld_c, din_c, busy_c, done_c, ok_c;
    logic [15:0] blk_len_c;
    logic [23:0] syn_c;

    vdec_hs_crc_chk u_dut_a (
        .clk(clk), .rst_n(rst_n), .blk_start(blk_start_a), .blk_len(blk_len_a),
        .din_vld(din_vld_a), .din(din_a), .busy(busy_a), .crc_done(done_a),
        .crc_ok(ok_a), .crc_syn(syn_a)
    );

    vdec_hs_crc_chk #(.DATA_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .blk_start(blk_start_b), .blk_len(blk_len_b),
        .din_vld(din_vld_b), .din(din_b), .busy(busy_b), .crc_done(done_b),
        .crc_ok(ok_b), .crc_syn(syn_b)
    );

    vdec_hs_crc_chk #(.CRC_W(24), .POLY(24'h800063)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .blk_start(blk_start_c), .blk_len(blk_len_c),
        .din_vld(din_vld_c), .din(din_c), .busy(busy_c), .crc_done(done_c),
        .crc_ok(ok_c), .crc_syn(syn_c)
    );

    // Count every crc_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (done_a === 1'b1) dcnt_a <= dcnt_a + 1;
        if (done_b === 1'b1) dcnt_b <= dcnt_b + 1;
        if (done_c === 1'b1) dcnt_c <= dcnt_c + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Classic MSB-first CRC (augmented form) producing the parity to append.
    function automatic logic [23:0] crc24_ref(input logic [39:0] bits);
        logic [23:0] c;
        logic        fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[23] ^ bits[i];
            c  = {c[22:0], 1'b0};
            if (fb) c = c ^ 24'h800063;
        end
        return c;
    endfunction

    task automatic start_a(input logic [15:0] len);
        blk_start_a = 1'b1; blk_len_a = len; din_vld_a = 1'b1; din_a = 1'b1;
        step();
        blk_start_a = 1'b0; din_vld_a = 1'b0;
    endtask

    task automatic feed_a(input int n, input logic [87:0] bits, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                din_vld_a = 1'b0; din_a = 1'($urandom);
                step();
            end
            din_vld_a = 1'b1; din_a = bits[i];
            step();
        end
        din_vld_a = 1'b0;
    endtask

    task automatic start_b(input logic [15:0] len);
        blk_start_b = 1'b1; blk_len_b = len; din_vld_b = 1'b1; din_b = 8'hFF;
        step();
        blk_start_b = 1'b0; din_vld_b = 1'b0;
    endtask

    task automatic feed_b(input int n, input logic [87:0] bits, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                din_vld_b = 1'b0; din_b = 8'($urandom);
                step();
            end
            din_vld_b = 1'b1; din_b = bits[i*8 +: 8];
            step();
        end
        din_vld_b = 1'b0;
    endtask

    task automatic start_c(input logic [15:0] len);
        blk_start_c = 1'b1; blk_len_c = len; din_vld_c = 1'b1; din_c = 1'b1;
        step();
        blk_start_c = 1'b0; din_vld_c = 1'b0;
    endtask

    task automatic feed_c(input logic [63:0] bits);
        for (int i = 63; i >= 0; i--) begin
            din_vld_c = 1'b1; din_c = bits[i];
            step();
        end
        din_vld_c = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
        checks++; if (ok_a !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", ok_a); end
        checks++; if (syn_a !== 16'h0) begin errors++; $display("FAIL reset_syn: got %h want 0000", syn_a); end
        checks++; if (busy_b !== 1'b0 || busy_c !== 1'b0) begin errors++; $display("FAIL reset_busy_bc: got %b%b want 00", busy_b, busy_c); end
    endtask

    task automatic test_check_string();
        base = dcnt_a;
        start_a(16'd72);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL str_busy: got %b want 1", busy_a); end
        feed_a(88, GOOD, 1'b0);
        // 1 start cycle + 88 bit cycles: crc_done is visible now, 89 cycles after blk_start.
        checks++; if (dcnt_a !== base) begin errors++; $display("FAIL str_early_done: got %0d pulses want 0", dcnt_a - base); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL str_done: got %b want 1", done_a); end
        checks++; if (ok_a !== 1'b1) begin errors++; $display("FAIL str_ok: got %b want 1", ok_a); end
        checks++; if (syn_a !== 16'h0) begin errors++; $display("FAIL str_syn: got %h want 0000", syn_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL str_busy_done: got %b want 0", busy_a); end
        step();
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL str_done_pulse: got %b want 0", done_a); end
        checks++; if (dcnt_a !== base + 1) begin errors++; $display("FAIL str_pulses: got %0d want 1", dcnt_a - base); end
    endtask

    task automatic test_idle_ignore();
        base = dcnt_a;
        for (int i = 0; i < 6; i++) begin
            din_vld_a = 1'b1; din_a = 1'($urandom);
            step();
        end
        din_vld_a = 1'b0;
        step();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_a); end
        checks++; if (ok_a !== 1'b1 || syn_a !== 16'h0) begin errors++; $display("FAIL idle_hold: got ok %b syn %h want 1 0000", ok_a, syn_a); end
        checks++; if (dcnt_a !== base) begin errors++; $display("FAIL idle_done: got %0d pulses want 0", dcnt_a - base); end
    endtask

    task automatic test_bad_parity();
        start_a(16'd72);
        feed_a(88, BAD, 1'b0);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL bad_done: got %b want 1", done_a); end
        checks++; if (ok_a !== 1'b0) begin errors++; $display("FAIL bad_ok: got %b want 0", ok_a); end
        // Flipping the final parity bit leaves a syndrome of exactly 1.
        checks++; if (syn_a !== 16'h0001) begin errors++; $display("FAIL bad_syn: got %h want 0001", syn_a); end
        step();
    endtask

    task automatic test_stall();
        start_a(16'd72);
        feed_a(88, GOOD, 1'b1);
        checks++; if (done_a !== 1'b1 || ok_a !== 1'b1) begin errors++; $display("FAIL stall_result: got done %b ok %b want 1 1", done_a, ok_a); end
        checks++; if (syn_a !== 16'h0) begin errors++; $display("FAIL stall_syn: got %h want 0000", syn_a); end
        step();
    endtask

    task automatic test_zero_len();
        start_a(16'd0);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL zlen_busy: got %b want 1", busy_a); end
        feed_a(15, 88'd0, 1'b0);
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL zlen_early: got done %b busy %b want 0 1", done_a, busy_a); end
        feed_a(1, 88'd0, 1'b0);
        checks++; if (done_a !== 1'b1 || ok_a !== 1'b1) begin errors++; $display("FAIL zlen_result: got done %b ok %b want 1 1", done_a, ok_a); end
        step();
    endtask

    task automatic test_abort();
        logic [95:0] tmp;
        tmp  = {$urandom, $urandom, $urandom};
        base = dcnt_a;
        start_a(16'd72);
        feed_a(30, tmp[87:0], 1'b0);
        start_a(16'd72);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy_a); end
        feed_a(88, GOOD, 1'b0);
        checks++; if (done_a !== 1'b1 || ok_a !== 1'b1) begin errors++; $display("FAIL abort_result: got done %b ok %b want 1 1", done_a, ok_a); end
        step();
        checks++; if (dcnt_a !== base + 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", dcnt_a - base); end
    endtask

    task automatic test_reset_mid();
        base = dcnt_a;
        start_a(16'd72);
        feed_a(80, GOOD >> 8, 1'b0);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b want 1", busy_a); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL rmid_state: got busy %b done %b want 0 0", busy_a, done_a); end
        checks++; if (ok_a !== 1'b0 || syn_a !== 16'h0) begin errors++; $display("FAIL rmid_result: got ok %b syn %h want 0 0000", ok_a, syn_a); end
        feed_a(8, GOOD, 1'b0);
        step();
        checks++; if (dcnt_a !== base || busy_a !== 1'b0) begin errors++; $display("FAIL rmid_idle: got pulses %0d busy %b want 0 0", dcnt_a - base, busy_a); end
        start_a(16'd72);
        feed_a(88, GOOD, 1'b0);
        checks++; if (done_a !== 1'b1 || ok_a !== 1'b1) begin errors++; $display("FAIL rmid_next: got done %b ok %b want 1 1", done_a, ok_a); end
        step();
    endtask

    task automatic test_done_restart();
        base = dcnt_a;
        start_a(16'd72);
        feed_a(88, GOOD, 1'b0);
        checks++; if (done_a !== 1'b1 || ok_a !== 1'b1) begin errors++; $display("FAIL drs_first: got done %b ok %b want 1 1", done_a, ok_a); end
        blk_start_a = 1'b1; blk_len_a = 16'd72; din_vld_a = 1'b1; din_a = 1'b1;
        step();
        blk_start_a = 1'b0; din_vld_a = 1'b0;
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL drs_restart: got done %b busy %b want 0 1", done_a, busy_a); end
        checks++; if (ok_a !== 1'b0) begin errors++; $display("FAIL drs_clear_ok: got %b want 0", ok_a); end
        feed_a(88, BAD, 1'b0);
        checks++; if (ok_a !== 1'b0 || syn_a !== 16'h0001) begin errors++; $display("FAIL drs_second: got ok %b syn %h want 0 0001", ok_a, syn_a); end
        step();
        checks++; if (dcnt_a !== base + 2) begin errors++; $display("FAIL drs_pulses: got %0d want 2", dcnt_a - base); end
    endtask

    task automatic test_data8();
        base = dcnt_b;
        start_b(16'd72);
        feed_b(11, GOOD, 1'b0);
        // 1 start cycle + 11 byte cycles: crc_done 12 cycles after blk_start.
        checks++; if (dcnt_b !== base || done_b !== 1'b1) begin errors++; $display("FAIL d8_timing: got early %0d done %b want 0 1", dcnt_b - base, done_b); end
        checks++; if (ok_b !== 1'b1 || syn_b !== 16'h0 || busy_b !== 1'b0) begin errors++; $display("FAIL d8_result: got ok %b syn %h busy %b want 1 0000 0", ok_b, syn_b, busy_b); end
        step();
        // blk_len 75 truncates to 72 at 8 bits per cycle.
        start_b(16'd75);
        feed_b(11, GOOD, 1'b1);
        checks++; if (done_b !== 1'b1 || ok_b !== 1'b1 || syn_b !== 16'h0) begin errors++; $display("FAIL d8_gaps: got done %b ok %b syn %h want 1 1 0000", done_b, ok_b, syn_b); end
        step();
    endtask

    task automatic test_crc24();
        logic [63:0] tmp;
        logic [63:0] msg;
        logic [63:0] one;
        logic [39:0] pl;
        tmp = {$urandom, $urandom};
        pl  = tmp[39:0];
        msg = {pl, crc24_ref(pl)};
        start_c(16'd40);
        feed_c(msg);
        checks++; if (done_c !== 1'b1 || ok_c !== 1'b1) begin errors++; $display("FAIL c24_good: got done %b ok %b want 1 1", done_c, ok_c); end
        checks++; if (syn_c !== 24'h0 || busy_c !== 1'b0) begin errors++; $display("FAIL c24_syn: got syn %h busy %b want 000000 0", syn_c, busy_c); end
        step();
        one = 64'd1;
        msg = msg ^ (one << (24 + $urandom_range(0, 39)));
        start_c(16'd40);
        feed_c(msg);
        checks++; if (done_c !== 1'b1 || ok_c !== 1'b0) begin errors++; $display("FAIL c24_flip: got done %b ok %b want 1 0", done_c, ok_c); end
        checks++; if (syn_c === 24'h0) begin errors++; $display("FAIL c24_flip_syn: got %h want nonzero", syn_c); end
        step();
        checks++; if (dcnt_c !== 2) begin errors++; $display("FAIL c24_pulses: got %0d want 2", dcnt_c); end
    endtask

    initial begin
        rst_n = 1'b0;
        blk_start_a = 1'b0; blk_len_a = '0; din_vld_a = 1'b0; din_a = 1'b0;
        blk_start_b = 1'b0; blk_len_b = '0; din_vld_b = 1'b0; din_b = '0;
        blk_start_c = 1'b0; blk_len_c = '0; din_vld_c = 1'b0; din_c = 1'b0;
        test_reset();
        test_check_string();
        test_idle_ignore();
        test_bad_parity();
        test_stall();
        test_zero_len();
        test_abort();
        test_reset_mid();
        test_done_restart();
        test_data8();
        test_crc24();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
